// File: rtl/bp_panel_ctrl_pkg.sv
//==============================================================================
// Module : bp_panel_ctrl_pkg
// Brief  : Shared widths, button indices and saturating helpers for the
//          front-panel controller.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

`ifndef BP_DEBOUNCE_DEFAULT
`define BP_DEBOUNCE_DEFAULT 20'd500000
`endif
`ifndef BP_REPEAT_DELAY_DEFAULT
`define BP_REPEAT_DELAY_DEFAULT 24'd10000000
`endif
`ifndef BP_REPEAT_PERIOD_DEFAULT
`define BP_REPEAT_PERIOD_DEFAULT 24'd2500000
`endif

package bp_panel_ctrl_pkg;

    localparam int c_DEB_W   = 20;
    localparam int c_RPT_W   = 24;
    localparam int c_NUM_BTN = 4;

    localparam int c_BTN_STEP = 0;
    localparam int c_BTN_CONT = 1;
    localparam int c_BTN_LOAD = 2;
    localparam int c_BTN_DISP = 3;

    function automatic logic [c_DEB_W-1:0] sat_inc_deb(input logic [c_DEB_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [c_RPT_W-1:0] sat_inc_rpt(input logic [c_RPT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_panel_ctrl_debounce.sv
//==============================================================================
// Module : debounce
// Brief  : Two-flop synchronizer, stability counter and debounced level with a
//          registered single-cycle rise indication.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

`ifndef BP_DEBOUNCE_DEFAULT
`define BP_DEBOUNCE_DEFAULT 20'd500000
`endif

module debounce
    import bp_panel_ctrl_pkg::*;
#(
    parameter logic [c_DEB_W-1:0] DEBOUNCE_CYCLES = `BP_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_rise;
    logic [c_DEB_W-1:0] r_cnt;

    logic w_differ;
    logic w_expire;

    assign w_differ = r_sync2 ^ r_level;
    // Comparing with >= keeps the flip reachable even if the counter saturated.
    assign w_expire = w_differ && (r_cnt >= (DEBOUNCE_CYCLES - 20'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= w_expire & ~r_level;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_expire) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= sat_inc_deb(r_cnt);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/bp_panel_ctrl.sv
//==============================================================================
// Module : bp_panel_ctrl
// Brief  : Front-panel controller: debounced buttons, address-byte latch,
//          display toggle and step/continue strobes with step auto-repeat.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

`ifndef BP_DEBOUNCE_DEFAULT
`define BP_DEBOUNCE_DEFAULT 20'd500000
`endif
`ifndef BP_REPEAT_DELAY_DEFAULT
`define BP_REPEAT_DELAY_DEFAULT 24'd10000000
`endif
`ifndef BP_REPEAT_PERIOD_DEFAULT
`define BP_REPEAT_PERIOD_DEFAULT 24'd2500000
`endif

module bp_panel_ctrl
    import bp_panel_ctrl_pkg::*;
#(
    parameter logic [c_DEB_W-1:0] DEBOUNCE_CYCLES = `BP_DEBOUNCE_DEFAULT,
    parameter logic [c_RPT_W-1:0] REPEAT_DELAY    = `BP_REPEAT_DELAY_DEFAULT,
    parameter logic [c_RPT_W-1:0] REPEAT_PERIOD   = `BP_REPEAT_PERIOD_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] sw_in,
    input  logic       btn_step_in,
    input  logic       btn_continue_in,
    input  logic       btn_load_in,
    input  logic       btn_disp_in,
    output logic [7:0] bp_addr_part_in,
    output logic       bp_hi_lo_sel_in,
    output logic       bp_hi_lo_disp_in,
    output logic       bp_step,
    output logic       bp_continue
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_BLOCK  = 2'd3
    } step_state_t;

    logic [c_NUM_BTN-1:0] w_raw;
    logic [c_NUM_BTN-1:0] w_level;
    logic [c_NUM_BTN-1:0] w_rise;
    logic                 w_unused_levels;
    logic                 w_step_lvl;
    logic                 w_step_rise;
    logic                 w_cont_rise;
    logic                 w_load_rise;
    logic                 w_disp_rise;

    logic [7:0]         r_sw_meta;
    logic [7:0]         r_sw_sync;
    logic [7:0]         r_part;
    logic               r_sel;
    logic               r_disp;
    logic               r_step;
    logic               r_cont;
    step_state_t        r_state;
    logic [c_RPT_W-1:0] r_rcnt;

    assign w_raw[c_BTN_STEP] = btn_step_in;
    assign w_raw[c_BTN_CONT] = btn_continue_in;
    assign w_raw[c_BTN_LOAD] = btn_load_in;
    assign w_raw[c_BTN_DISP] = btn_disp_in;

    for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clock),
            .rst     (reset),
            .i_raw   (w_raw[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    // Only the step button needs its held level; the others act on rises alone.
    assign w_unused_levels = ^w_level[c_NUM_BTN-1:1];

    assign w_step_lvl  = w_level[c_BTN_STEP];
    assign w_step_rise = w_rise[c_BTN_STEP];
    assign w_cont_rise = w_rise[c_BTN_CONT];
    assign w_load_rise = w_rise[c_BTN_LOAD];
    assign w_disp_rise = w_rise[c_BTN_DISP];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_part  <= 8'hff;
            r_sel   <= 1'b0;
            r_disp  <= 1'b0;
            r_step  <= 1'b0;
            r_cont  <= 1'b0;
            r_state <= S_IDLE;
            r_rcnt  <= '0;
        end else begin
            r_sel  <= 1'b0;
            r_step <= 1'b0;
            r_cont <= 1'b0;

            if (w_load_rise) begin
                r_part <= r_sw_sync;
                r_sel  <= 1'b1;
            end
            if (w_disp_rise) begin
                r_disp <= ~r_disp;
            end

            // Continue pre-empts the step machine, including a same-cycle step rise.
            if (w_cont_rise) begin
                r_cont  <= 1'b1;
                r_rcnt  <= '0;
                r_state <= w_step_lvl ? S_BLOCK : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_step_rise) begin
                            r_step  <= 1'b1;
                            r_rcnt  <= '0;
                            r_state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (!w_step_lvl) begin
                            r_state <= S_IDLE;
                        end else if ((REPEAT_DELAY != 24'd0) &&
                                     (r_rcnt == (REPEAT_DELAY - 24'd1))) begin
                            r_step  <= 1'b1;
                            r_rcnt  <= '0;
                            r_state <= S_REPEAT;
                        end else begin
                            r_rcnt <= sat_inc_rpt(r_rcnt);
                        end
                    end
                    S_REPEAT: begin
                        if (!w_step_lvl) begin
                            r_state <= S_IDLE;
                        end else if (r_rcnt >= (REPEAT_PERIOD - 24'd1)) begin
                            r_step <= 1'b1;
                            r_rcnt <= '0;
                        end else begin
                            r_rcnt <= sat_inc_rpt(r_rcnt);
                        end
                    end
                    S_BLOCK: begin
                        if (!w_step_lvl) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bp_addr_part_in  = r_part;
    assign bp_hi_lo_sel_in  = r_sel;
    assign bp_hi_lo_disp_in = r_disp;
    assign bp_step          = r_step;
    assign bp_continue      = r_cont;

endmodule

`default_nettype wire

// File: doc/bp_panel_ctrl.md
# bp_panel_ctrl

Front-panel controller that turns raw board buttons and an 8-bit switch bank into the clean, single-cycle control strobes consumed by the `breakpoints` block and the CPU's step/continue inputs. It sits directly upstream of `breakpoints` and the CPU. It synchronizes and debounces every button and latches the switch byte as a breakpoint-address part. It provides press-and-hold auto-repeat for single-stepping.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20'd500000: consecutive stable cycles required before a button's debounced level changes; must be ≥ 1.
- `REPEAT_DELAY`, default 24'd10000000: cycles step must stay held after its first pulse before auto-repeat starts; 0 disables repeat.
- `REPEAT_PERIOD`, default 24'd2500000: cycles between auto-repeat step pulses; must be ≥ 1.

Ports:
- `clock`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sw_in`  in  8  raw switch bank carrying the address byte. Asynchronous.
- `btn_step_in`  in  1  raw step button. Asynchronous, active-high.
- `btn_continue_in`  in  1  raw continue button.
- `btn_load_in`  in  1  raw button that loads the breakpoint address byte.
- `btn_disp_in`  in  1  raw button that toggles the hi/lo display select.
- `bp_addr_part_in`  out  8  latched address byte for `breakpoints`.
- `bp_hi_lo_sel_in`  out  1  one-cycle write strobe to `breakpoints`.
- `bp_hi_lo_disp_in`  out  1  display-half select level.
- `bp_step`  out  1  one-cycle step pulse to the CPU.
- `bp_continue`  out  1  one-cycle continue pulse to the CPU.

## Operation
- Every raw input passes through a 2-flop synchronizer; `sw_in` is synchronized as a bus.
- Debounce, per button:
  - A counter tracks how long the synchronized value has differed from the debounced level.
  - When it has differed for `DEBOUNCE_CYCLES` consecutive cycles, the debounced level flips.
  - Any cycle where the value matches the debounced level clears the counter.
- A rise is the debounced level going 0→1. Falls generate nothing except FSM release.
- Load rise:
  - `bp_addr_part_in` takes the synchronized `sw_in` on the same edge.
  - `bp_hi_lo_sel_in` is high for exactly the following cycle.
  - The part value holds until the next load.
- Disp rise: `bp_hi_lo_disp_in` toggles.
- Continue rise: `bp_continue` is high for one cycle.
- Step FSM states are `S_IDLE`, `S_HOLD`, `S_REPEAT` and `S_BLOCK`:
  - `S_IDLE`, step rise: pulse `bp_step`, clear the counter, go to `S_HOLD`.
  - `S_HOLD`, step released: go to `S_IDLE`.
  - `S_HOLD`, counter = `REPEAT_DELAY`−1 with `REPEAT_DELAY`≠0: pulse, clear the counter, go to `S_REPEAT`.
  - `S_REPEAT`, counter = `REPEAT_PERIOD`−1: pulse and clear the counter. Release goes to `S_IDLE`.
  - `S_BLOCK`: no pulses until step is released, then go to `S_IDLE`.
- Priority and conflicts:
  - Continue rise in any step state: continue pulses and the step FSM goes to `S_BLOCK` if step is held, else `S_IDLE`.
  - Step and continue rising in the same cycle: only `bp_continue` pulses, and the FSM goes to `S_BLOCK`.
  - `bp_step` and `bp_continue` are never high in the same cycle.
- Load and disp are independent of step/continue. Simultaneous events are all honoured.

## Timing
- Reset values, applied at the first rising edge with `reset` high:
  - `bp_addr_part_in` = 8'hff.
  - `bp_hi_lo_sel_in`, `bp_hi_lo_disp_in`, `bp_step`, `bp_continue` = 0.
  - Debounced levels = 0, counters = 0, FSM = `S_IDLE`, synchronizers = 0.
- Latency: a raw input that goes high just before edge k and stays high gives an output pulse in the cycle after edge k+1+`DEBOUNCE_CYCLES`, i.e. the pulse is registered at edge k+2+`DEBOUNCE_CYCLES`.
- All outputs are registered, with no combinational path from inputs.
- Reset mid-press:
  - Outputs clear immediately.
  - A button still held after reset must debounce again and then produces a fresh rise.
- Auto-repeat spacing: the first step pulse, then a second pulse `REPEAT_DELAY` cycles later, then one every `REPEAT_PERIOD` cycles.
- Counters saturate rather than wrap.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes a debounced level.

## Structure
- Add `` `BP_DEBOUNCE_DEFAULT ``, `` `BP_REPEAT_DELAY_DEFAULT `` and `` `BP_REPEAT_PERIOD_DEFAULT `` to `cpu.vh`; parameter defaults reference them.
- Step FSM state encodings are localparams in this module.
- One sub-module, `debounce`, containing the 2-flop synchronizer, counter and debounced level plus a registered `rise` output. It is instantiated once per button.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
1. Reset: hold reset 2 cycles → `bp_addr_part_in`=8'hff and all other outputs 0.
2. Load: `sw_in`=8'h03, press load for 10 cycles → `bp_addr_part_in`=8'h03, and `bp_hi_lo_sel_in` is high for one cycle exactly 6 edges after the press.
3. Repeat the load with `sw_in`=8'h00 → part 8'h00 and one strobe.
4. Disp pressed twice → `bp_hi_lo_disp_in` goes 1 then back to 0.
5. Bounce: step toggled every 2 cycles for 20 cycles then released → no `bp_step` pulse.
6. Auto-repeat: step held 30 debounced cycles → pulses at relative cycles 0, 10, 13, 16, 19, 22, 25, 28, then none after release.
7. Conflict: step and continue pressed on the same cycle and held 20 cycles → one `bp_continue` pulse, zero `bp_step` pulses.
8. Step pressed again after release → one `bp_step`.
9. Reset asserted during `S_REPEAT` → pulses stop; step still held → a new first pulse after re-debounce.
